// File: rtl/crtc_timing_if.sv
// crtc_timing_if: bundles the CRTC register-file inputs, the char strobe and the timing outputs.
// master drives char_en and the R0-R13 values and receives the timing outputs.
// slave is the timing generator.
interface crtc_timing_if #(parameter int MA_WIDTH = 14);
  logic                char_en;
  logic [7:0]          r0_h_total;
  logic [7:0]          r1_h_displayed;
  logic [7:0]          r2_h_sync_pos;
  logic [7:0]          r3_sync_widths;
  logic [6:0]          r4_v_total;
  logic [4:0]          r5_v_adjust;
  logic [6:0]          r6_v_displayed;
  logic [6:0]          r7_v_sync_pos;
  logic [4:0]          r9_max_scan_line;
  logic [5:0]          r12_start_hi;
  logic [7:0]          r13_start_lo;
  logic                h_sync;
  logic                v_sync;
  logic                de;
  logic [MA_WIDTH-1:0] ma;
  logic [4:0]          ra;
  logic                frame_start;
  modport master (
    output char_en, r0_h_total, r1_h_displayed, r2_h_sync_pos, r3_sync_widths, r4_v_total,
           r5_v_adjust, r6_v_displayed, r7_v_sync_pos, r9_max_scan_line, r12_start_hi, r13_start_lo,
    input  h_sync, v_sync, de, ma, ra, frame_start
  );
  modport slave (
    input  char_en, r0_h_total, r1_h_displayed, r2_h_sync_pos, r3_sync_widths, r4_v_total,
           r5_v_adjust, r6_v_displayed, r7_v_sync_pos, r9_max_scan_line, r12_start_hi, r13_start_lo,
    output h_sync, v_sync, de, ma, ra, frame_start
  );
endinterface

// File: rtl/crtc_timing.sv
// crtc_timing: character/raster timing generator producing syncs, display enable, MA and RA.
// clk, res_b (async active-low reset); bus (slave): char_en strobe and live R0-R9/R12/R13
// inputs, h_sync/v_sync/de/ma/ra/frame_start outputs. All state advances only on char_en.
module crtc_timing #(parameter int MA_WIDTH = 14) (
  input logic          clk,
  input logic          res_b,
  crtc_timing_if.slave bus
);
  typedef enum logic {ROWS, ADJUST} state_t;
  state_t              state, state_n;
  logic [7:0]          h_count, h_n;
  logic [4:0]          ra, ra_n, adj_count, adj_n, hsync_cnt, vsync_cnt, hw, vw;
  logic [6:0]          row_count, row_n;
  logic [MA_WIDTH-1:0] ma_row, ma_row_n;
  logic                h_sync, v_sync, de, frame_start;
  logic                eol, new_frame, hs_start, hs_done, vs_start, vs_done;
  always_comb begin
    eol = h_count == bus.r0_h_total;
    h_n = eol ? 8'd0 : h_count + 8'd1;
    // a width field of 0 means 16
    hw = {bus.r3_sync_widths[3:0] == 4'd0, bus.r3_sync_widths[3:0]};
    vw = {bus.r3_sync_widths[7:4] == 4'd0, bus.r3_sync_widths[7:4]};
    state_n = state;
    ra_n = ra;
    row_n = row_count;
    adj_n = adj_count;
    ma_row_n = ma_row;
    new_frame = 1'b0;
    if (eol) begin
      ra_n = ra + 5'd1;
      if (state == ROWS) begin
        if (ra == bus.r9_max_scan_line) begin
          ra_n = 5'd0;
          if (row_count != bus.r4_v_total) begin
            row_n = row_count + 7'd1;
            ma_row_n = ma_row + MA_WIDTH'(bus.r1_h_displayed);
          end else if (bus.r5_v_adjust != 5'd0) begin
            state_n = ADJUST;
            adj_n = 5'd0;
          end else begin
            new_frame = 1'b1;
          end
        end
      end else begin
        adj_n = adj_count + 5'd1;
        new_frame = adj_count == bus.r5_v_adjust - 5'd1;
      end
      if (new_frame) begin
        state_n = ROWS;
        ra_n = 5'd0;
        row_n = 7'd0;
        adj_n = 5'd0;
        ma_row_n = MA_WIDTH'({bus.r12_start_hi, bus.r13_start_lo});
      end
    end
    hs_start = h_n == bus.r2_h_sync_pos && bus.r2_h_sync_pos <= bus.r0_h_total;
    hs_done = h_sync && hsync_cnt == hw;
    vs_start = eol && state_n == ROWS && ra_n == 5'd0 && row_n == bus.r7_v_sync_pos;
    vs_done = v_sync && vsync_cnt == vw;
  end
  // a sync pulse in progress is not retriggered; a new start is honoured only once it completes
  always_ff @(posedge clk or negedge res_b) begin
    if (!res_b) begin
      state <= ROWS;
      h_count <= 8'd0;
      ra <= 5'd0;
      row_count <= 7'd0;
      adj_count <= 5'd0;
      ma_row <= '0;
      hsync_cnt <= 5'd0;
      vsync_cnt <= 5'd0;
      h_sync <= 1'b0;
      v_sync <= 1'b0;
      de <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (bus.char_en) begin
        h_count <= h_n;
        state <= state_n;
        ra <= ra_n;
        row_count <= row_n;
        adj_count <= adj_n;
        ma_row <= ma_row_n;
        frame_start <= new_frame;
        de <= state_n == ROWS && h_n < bus.r1_h_displayed && row_n < bus.r6_v_displayed;
        if (hs_start && (!h_sync || hs_done)) begin
          h_sync <= 1'b1;
          hsync_cnt <= 5'd1;
        end else if (hs_done) begin
          h_sync <= 1'b0;
          hsync_cnt <= 5'd0;
        end else if (h_sync) begin
          hsync_cnt <= hsync_cnt + 5'd1;
        end
        if (eol) begin
          if (vs_start && (!v_sync || vs_done)) begin
            v_sync <= 1'b1;
            vsync_cnt <= 5'd1;
          end else if (vs_done) begin
            v_sync <= 1'b0;
            vsync_cnt <= 5'd0;
          end else if (v_sync) begin
            vsync_cnt <= vsync_cnt + 5'd1;
          end
        end
      end
    end
  end
  assign bus.h_sync = h_sync;
  assign bus.v_sync = v_sync;
  assign bus.de = de;
  assign bus.frame_start = frame_start;
  assign bus.ra = ra;
  assign bus.ma = ma_row + MA_WIDTH'(h_count);
endmodule

// File: tb/tb_crtc_timing.sv
// tb_crtc_timing: table-driven scoreboard bench for crtc_timing against a closed-form raster model.
module tb_crtc_timing;
  logic clk = 1'b0;
  logic res_b = 1'b0;
  always #5 clk = ~clk;
  crtc_timing_if #(.MA_WIDTH(14)) bus();
  crtc_timing #(.MA_WIDTH(14)) dut (.clk(clk), .res_b(res_b), .bus(bus));
  typedef struct {
    logic [7:0] r0, r1, r2, r3;
    logic [6:0] r4, r6, r7;
    logic [4:0] r5, r9;
    logic [5:0] r12;
    logic [7:0] r13;
    int         steps;
  } cfg_t;
  typedef struct packed {
    logic        hs, vs, de, fs;
    logic [13:0] ma;
    logic [4:0]  ra;
  } out_t;
  typedef struct {
    int   ci;
    int   t;
    out_t e;
  } spot_t;
  cfg_t  cfgs[5];
  spot_t spots[$];
  out_t  q[$];
  int    total = 0;
  int    bad = 0;
  function automatic out_t mk(logic hs, logic vs, logic de, logic fs, logic [13:0] ma, logic [4:0] ra);
    return {hs, vs, de, fs, ma, ra};
  endfunction
  function automatic cfg_t mk_cfg(logic [7:0] r0, logic [7:0] r1, logic [7:0] r2, logic [7:0] r3,
                                  logic [6:0] r4, logic [4:0] r5, logic [6:0] r6, logic [6:0] r7,
                                  logic [4:0] r9, logic [13:0] start, int steps);
    cfg_t c;
    c.r0 = r0; c.r1 = r1; c.r2 = r2; c.r3 = r3; c.r4 = r4; c.r5 = r5; c.r6 = r6; c.r7 = r7;
    c.r9 = r9; c.r12 = start[13:8]; c.r13 = start[7:0]; c.steps = steps;
    return c;
  endfunction
  // Expected outputs after t char_ens since reset, computed from absolute line/frame position.
  function automatic out_t model(cfg_t c, int t);
    int L, rl, rows_lines, F, h, la, fr, ln, row, ra, base, w, v, hp, vp, s;
    bit in_rows;
    out_t e;
    L = int'(c.r0) + 1;
    rl = int'(c.r9) + 1;
    rows_lines = (int'(c.r4) + 1) * rl;
    F = rows_lines + int'(c.r5);
    h = t % L;
    la = t / L;
    fr = la / F;
    ln = la % F;
    in_rows = ln < rows_lines;
    row = in_rows ? ln / rl : int'(c.r4);
    ra = in_rows ? ln % rl : ln - rows_lines;
    base = (fr == 0) ? 0 : int'({c.r12, c.r13});
    w = (c.r3[3:0] == 4'd0) ? 16 : int'(c.r3[3:0]);
    v = (c.r3[7:4] == 4'd0) ? 16 : int'(c.r3[7:4]);
    hp = ((w + L - 1) / L) * L;
    vp = ((v + F - 1) / F) * F;
    s = int'(c.r7) * rl;
    e.ma = 14'(base + row * int'(c.r1) + h);
    e.ra = 5'(ra);
    e.de = in_rows && h < int'(c.r1) && row < int'(c.r6);
    e.fs = t > 0 && t % (L * F) == 0;
    e.hs = c.r2 <= c.r0 && t >= int'(c.r2) && (t - int'(c.r2)) % hp < w;
    e.vs = la >= s && (la - s) % vp < v;
    return e;
  endfunction
  function automatic out_t sample();
    return {bus.h_sync, bus.v_sync, bus.de, bus.frame_start, bus.ma, bus.ra};
  endfunction
  task automatic check(string name, out_t a, out_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got hs=%b vs=%b de=%b fs=%b ma=%h ra=%0d, want hs=%b vs=%b de=%b fs=%b ma=%h ra=%0d",
               name, a.hs, a.vs, a.de, a.fs, a.ma, a.ra, e.hs, e.vs, e.de, e.fs, e.ma, e.ra);
    end
  endtask
  task automatic add_spot(int ci, int t, out_t e);
    spot_t sp;
    sp.ci = ci; sp.t = t; sp.e = e;
    spots.push_back(sp);
  endtask
  task automatic apply(cfg_t c);
    bus.r0_h_total = c.r0; bus.r1_h_displayed = c.r1; bus.r2_h_sync_pos = c.r2;
    bus.r3_sync_widths = c.r3; bus.r4_v_total = c.r4; bus.r5_v_adjust = c.r5;
    bus.r6_v_displayed = c.r6; bus.r7_v_sync_pos = c.r7; bus.r9_max_scan_line = c.r9;
    bus.r12_start_hi = c.r12; bus.r13_start_lo = c.r13;
  endtask
  task automatic do_reset(cfg_t c);
    @(negedge clk);
    res_b = 1'b0;
    bus.char_en = 1'b0;
    apply(c);
    repeat (2) @(negedge clk);
    res_b = 1'b1;
  endtask
  task automatic step(int ci, int t);
    out_t a, e;
    @(negedge clk);
    bus.char_en = 1'b1;
    q.push_back(model(cfgs[ci], t));
    @(negedge clk);
    bus.char_en = 1'b0;
    a = sample();
    e = q.pop_front();
    check($sformatf("c%0d_t%0d", ci, t), a, e);
    foreach (spots[k])
      if (spots[k].ci == ci && spots[k].t == t) check($sformatf("spot_c%0d_t%0d", ci, t), a, spots[k].e);
  endtask
  initial begin
    cfgs[0] = mk_cfg(8'd9, 8'd6, 8'd7, 8'h12, 7'd3, 5'd0, 7'd2, 7'd2, 5'd1, 14'h0100, 170);
    cfgs[1] = mk_cfg(8'd9, 8'd6, 8'd7, 8'h02, 7'd3, 5'd3, 7'd2, 7'd2, 5'd1, 14'h0100, 270);
    cfgs[2] = mk_cfg(8'd0, 8'd20, 8'd5, 8'h12, 7'd3, 5'd0, 7'd2, 7'd2, 5'd1, 14'h0000, 40);
    cfgs[3] = mk_cfg(8'd9, 8'd20, 8'd7, 8'h12, 7'd3, 5'd0, 7'd2, 7'd2, 5'd1, 14'h0000, 90);
    cfgs[4] = mk_cfg(8'd9, 8'd4, 8'd7, 8'h12, 7'd3, 5'd0, 7'd2, 7'd2, 5'd1, 14'h3FFE, 100);
    add_spot(0, 5, mk(0, 0, 1, 0, 14'h005, 0));
    add_spot(0, 6, mk(0, 0, 0, 0, 14'h006, 0));
    add_spot(0, 7, mk(1, 0, 0, 0, 14'h007, 0));
    add_spot(0, 8, mk(1, 0, 0, 0, 14'h008, 0));
    add_spot(0, 9, mk(0, 0, 0, 0, 14'h009, 0));
    add_spot(0, 10, mk(0, 0, 1, 0, 14'h000, 1));
    add_spot(0, 20, mk(0, 0, 1, 0, 14'h006, 0));
    add_spot(0, 40, mk(0, 1, 0, 0, 14'h00C, 0));
    add_spot(0, 47, mk(1, 1, 0, 0, 14'h013, 0));
    add_spot(0, 50, mk(0, 0, 0, 0, 14'h00C, 1));
    add_spot(0, 80, mk(0, 0, 1, 1, 14'h100, 0));
    add_spot(0, 81, mk(0, 0, 1, 0, 14'h101, 0));
    add_spot(0, 85, mk(0, 0, 1, 0, 14'h105, 0));
    add_spot(0, 86, mk(0, 0, 0, 0, 14'h106, 0));
    add_spot(0, 90, mk(0, 0, 1, 0, 14'h100, 1));
    add_spot(0, 100, mk(0, 0, 1, 0, 14'h106, 0));
    add_spot(0, 105, mk(0, 0, 1, 0, 14'h10B, 0));
    add_spot(1, 110, mk(0, 1, 1, 1, 14'h100, 0));
    add_spot(1, 199, mk(0, 1, 0, 0, 14'h11B, 0));
    add_spot(1, 200, mk(0, 0, 0, 0, 14'h112, 1));
    add_spot(1, 260, mk(0, 1, 0, 0, 14'h10C, 0));
    add_spot(2, 3, mk(0, 0, 1, 0, 14'd20, 1));
    add_spot(2, 4, mk(0, 1, 0, 0, 14'd40, 0));
    add_spot(2, 8, mk(0, 0, 1, 1, 14'd0, 0));
    add_spot(3, 9, mk(0, 0, 1, 0, 14'd9, 0));
    add_spot(3, 19, mk(0, 0, 1, 0, 14'd9, 1));
    add_spot(3, 20, mk(0, 0, 1, 0, 14'd20, 0));
    add_spot(4, 80, mk(0, 0, 1, 1, 14'h3FFE, 0));
    add_spot(4, 81, mk(0, 0, 1, 0, 14'h3FFF, 0));
    add_spot(4, 82, mk(0, 0, 1, 0, 14'h0000, 0));
    add_spot(4, 83, mk(0, 0, 1, 0, 14'h0001, 0));
    bus.char_en = 1'b0;
    apply(cfgs[0]);
    repeat (4) begin
      @(negedge clk);
      bus.char_en = 1'b1;
      @(negedge clk);
      bus.char_en = 1'b0;
      check("reset_hold", sample(), out_t'(0));
    end
    for (int ci = 0; ci < 5; ci++) begin
      do_reset(cfgs[ci]);
      for (int t = 1; t <= cfgs[ci].steps; t++) step(ci, t);
    end
    do_reset(cfgs[0]);
    for (int t = 1; t <= 47; t++) step(0, t);
    @(negedge clk);
    res_b = 1'b0;
    #1;
    check("mid_reset_async", sample(), out_t'(0));
    repeat (2) begin
      @(negedge clk);
      bus.char_en = 1'b1;
      @(negedge clk);
      bus.char_en = 1'b0;
      check("mid_reset_hold", sample(), out_t'(0));
    end
    res_b = 1'b1;
    @(negedge clk);
    check("post_release_idle", sample(), out_t'(0));
    for (int t = 1; t <= 12; t++) step(0, t);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/crtc_timing.md
Name: crtc_timing

Overview:
- Character/raster timing generator that consumes the CRTC register file outputs (R0–R9, R12, R13) and produces sync, display enable, video memory address (MA) and raster address (RA).
- Sits directly downstream of the crtc register block and feeds the video fetch/shift stage.
- Counters advance once per character time, qualified by a clock-enable strobe.

Parameters:
- MA_WIDTH, 14, width of video memory address output.

Ports:
- clk  in  1  system clock.
- res_b  in  1  reset, asynchronous, active-low.
- char_en  in  1  one-clk strobe per character time; all state advances only when high.
- r0_h_total  in  8  horizontal total, in chars, minus 1.
- r1_h_displayed  in  8  displayed chars per line.
- r2_h_sync_pos  in  8  char index where hsync starts.
- r3_sync_widths  in  8  [3:0] hsync width in chars; [7:4] vsync width in scan lines. 0 encodes 16.
- r4_v_total  in  7  char rows per frame, minus 1.
- r5_v_adjust  in  5  extra scan lines after the last row.
- r6_v_displayed  in  7  displayed char rows.
- r7_v_sync_pos  in  7  char row where vsync starts.
- r9_max_scan_line  in  5  scan lines per row, minus 1.
- r12_start_hi  in  6  start address high bits.
- r13_start_lo  in  8  start address low bits.
- h_sync  out  1  horizontal sync, active-high.
- v_sync  out  1  vertical sync, active-high.
- de  out  1  display enable.
- ma  out  MA_WIDTH  video memory address.
- ra  out  5  raster (scan line within row).
- frame_start  out  1  one-clk pulse coincident with the char_en that begins a new frame.

Behaviour:
- Reset (res_b low, asynchronous):
  - h_count, ra, row_count, adj_count, ma_row, hsync_cnt and vsync_cnt clear to 0.
  - State = ROWS.
  - h_sync = v_sync = de = frame_start = 0; ma = 0; ra = 0.
- Register inputs are sampled live at each char_en; no shadowing.
- Horizontal:
  - On char_en, h_count increments; if h_count == R0, it wraps to 0 (end of line).
  - R0 = 0: every char is end of line.
- Vertical FSM, evaluated at end of line:
  - ROWS:
    - If ra != R9: ra++.
    - Else ra = 0 and the row ends. If row_count != R4, then row_count++ and ma_row += R1. Otherwise go to ADJUST when R5 != 0, or start a new frame when R5 == 0.
  - ADJUST:
    - ra increments each line; adj_count++.
    - When adj_count == R5 − 1, start a new frame.
  - New frame:
    - row_count = 0, ra = 0, adj_count = 0.
    - ma_row = {R12, R13}, truncated or zero-extended to MA_WIDTH.
    - State = ROWS.
    - frame_start pulses.
  - The first frame after reset uses ma_row = 0.
- Outputs:
  - ma = ma_row + h_count, modulo 2^MA_WIDTH (wraps at 0x3FFF).
  - de = (state == ROWS) && (h_count < R1) && (row_count < R6).
  - R1 > R0: de stays high for the whole line. R1 = 0 or R6 = 0: de never asserts.
- hsync:
  - Asserts on the char_en where h_count becomes R2.
  - Deasserts after W chars, W = r3[3:0] (0 means 16).
  - If R2 > R0, hsync never asserts.
  - hsync_cnt runs independently of the line wrap, so sync may span the wrap.
- vsync:
  - Asserts at the start of line 0 of row R7 (state ROWS).
  - Deasserts after V scan lines, V = r3[7:4] (0 means 16).
  - vsync counts continue across frame boundaries.
- Latency: all outputs are registered or derived from registered state. They reflect the new counter values starting the clk after the char_en edge.
- Reset mid-frame: immediate return to reset values. The first char_en after release advances h_count to 1.

Test Plan:
- Reset values: hold res_b low, toggle char_en -> h_sync = v_sync = de = 0, ma = 0, ra = 0, frame_start = 0.
- Horizontal, R0 = 9, R1 = 6, R2 = 7, r3 = 0x12, R4 = 3, R9 = 1, R6 = 2, R5 = 0:
  - -> h_count cycles 0..9.
  - -> de high for h_count 0..5 on rows 0–1.
  - -> h_sync high exactly 2 chars (h_count 7, 8).
  - -> frame_start every 80 char_ens.
- Addressing, same setup with R12 = 0x01, R13 = 0x00:
  - -> second frame row 0 ma = 0x100..0x105.
  - -> row 1 ma = 0x106..0x10B.
  - -> ra toggles 0, 1 within each row.
- Adjust and vsync: R5 = 3, R7 = 2, r3[7:4] = 0 ->
  - -> frame length 4·2 + 3 = 11 lines, i.e. 110 char_ens.
  - -> v_sync high for 16 lines starting at row 2, line 0, spanning the frame wrap.
- Boundaries:
  - R0 = 0 -> every char ends a line.
  - R1 = 20 > R0 -> de continuously high during displayed rows.
  - {R12, R13} = 0x3FFE with R1 = 4 -> ma wraps 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Reset mid-operation: assert res_b low in row 2, mid-hsync -> all outputs return to 0 immediately; timing restarts from h_count 0 after release.
